bus_timer: RTL and testbench

- Memory-mapped timer peripheral; slave on the CPU data bus through the `Bus` interface, `s` modport.
- Provides a free-running or one-shot compare counter, a sticky event flag and the `irq` line consumed by the core.
- Sits directly downstream of the bus. Address decoding of the device base is done upstream; this block decodes only word offset `address[3:2]`.

---
 rtl/Types_pkg.sv | 20 ++
 rtl/Bus.sv | 24 ++
 rtl/byte_lane_write.sv | 22 ++
 rtl/bus_timer.sv | 156 +++++++++++++++
 tb/tb_bus_timer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/Types_pkg.sv
// Shared CPU data-bus types and peripheral register map constants.
// Imported by bus devices, their helpers and the bus interface.
package Types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;
  typedef logic [1:0]  regoff_t;

  localparam regoff_t TIMER_LIMIT  = 2'd0;
  localparam regoff_t TIMER_COUNT  = 2'd1;
  localparam regoff_t TIMER_CTRL   = 2'd2;
  localparam regoff_t TIMER_STATUS = 2'd3;

  localparam int unsigned TIMER_CTRL_RUN    = 0;
  localparam int unsigned TIMER_CTRL_IRQ_EN = 1;
  localparam int unsigned TIMER_CTRL_RELOAD = 2;

  localparam int unsigned TIMER_STATUS_EVENT = 0;

endpackage

// File: rtl/Bus.sv
// CPU data-bus slave port: valid/ready request with one data beat.
// Devices take the s side; the core drives the m side.
interface Bus;
  import Types_pkg::*;

  logic     valid;
  word_t    address;
  wstrobe_t wstrobe;
  word_t    wdata;
  logic     ready;
  word_t    rdata;
  logic     irq;

  modport s (
    input  valid, address, wstrobe, wdata,
    output ready, rdata, irq
  );

  modport m (
    output valid, address, wstrobe, wdata,
    input  ready, rdata, irq
  );

endinterface

// File: rtl/byte_lane_write.sv
// Merges bus write data into an existing word one byte lane at a time.
// Shared by bus devices with byte-writable registers.
module byte_lane_write
  import Types_pkg::*;
(
  input  word_t    old_i,
  input  word_t    wdata_i,
  input  wstrobe_t wstrobe_i,
  output word_t    word_o
);

  // Each strobed lane takes the new byte, the rest keep the old one.
  always_comb begin
    word_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (wstrobe_i[i]) begin
        word_o[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped compare timer with prescaler, sticky event and irq.
// Decodes only address[3:2]; the device base is decoded upstream.
module bus_timer
  import Types_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input logic clk,
  input logic reset,
  Bus.s       bus
);

  localparam int unsigned   PW    = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  word_t         limit_q, limit_d;
  word_t         count_q, count_d;
  logic          run_q, run_d;
  logic          ien_q, ien_d;
  logic          rel_q, rel_d;
  logic          event_q, event_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          ready_q, ready_d;
  word_t         rdata_q, rdata_d;

  regoff_t off;
  logic    accept;
  logic    wr;
  logic    wr_limit, wr_count, wr_ctrl, wr_status;
  logic    clr;
  logic    tick;
  logic    match;
  word_t   cur;
  word_t   merged;
  logic    unused_addr;

  assign off       = bus.address[3:2];
  assign accept    = bus.valid & ~ready_q;
  assign wr        = accept & (|bus.wstrobe);
  assign wr_limit  = wr & (off == TIMER_LIMIT);
  assign wr_count  = wr & (off == TIMER_COUNT);
  assign wr_ctrl   = wr & (off == TIMER_CTRL);
  assign wr_status = wr & (off == TIMER_STATUS);
  assign clr       = wr_status & bus.wstrobe[0]
                   & bus.wdata[TIMER_STATUS_EVENT];

  assign tick  = run_q & (pre_q == PLAST);
  assign match = tick & (count_q == limit_q);

  assign unused_addr = ^{bus.address[31:4], bus.address[1:0]};

  // Addressed register as seen before this edge's updates.
  always_comb begin
    cur = '0;
    unique case (off)
      TIMER_LIMIT:  cur = limit_q;
      TIMER_COUNT:  cur = count_q;
      TIMER_CTRL: begin
        cur[TIMER_CTRL_RUN]    = run_q;
        cur[TIMER_CTRL_IRQ_EN] = ien_q;
        cur[TIMER_CTRL_RELOAD] = rel_q;
      end
      TIMER_STATUS: cur[TIMER_STATUS_EVENT] = event_q;
      default:      cur = '0;
    endcase
  end

  byte_lane_write u_merge (
    .old_i     (cur),
    .wdata_i   (bus.wdata),
    .wstrobe_i (bus.wstrobe),
    .word_o    (merged)
  );

  // Counter/compare update; bus writes to COUNT or CTRL beat a tick.
  always_comb begin
    limit_d = limit_q;
    count_d = count_q;
    run_d   = run_q;
    ien_d   = ien_q;
    rel_d   = rel_q;
    event_d = event_q;
    if (tick && !wr_count && !wr_ctrl) begin
      if (match) begin
        if (rel_q) begin
          count_d = '0;
        end else begin
          run_d = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end
    if (wr_limit) begin
      limit_d = merged;
    end
    if (wr_count) begin
      count_d = merged;
    end
    if (wr_ctrl) begin
      run_d = merged[TIMER_CTRL_RUN];
      ien_d = merged[TIMER_CTRL_IRQ_EN];
      rel_d = merged[TIMER_CTRL_RELOAD];
    end
    if (clr) begin
      event_d = 1'b0;
    end
    if (match) begin
      event_d = 1'b1;
    end
  end

  // Prescaler runs 0..PRESCALE-1 while enabled, parked at 0 otherwise.
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (!run_q || tick) begin
      pre_d = '0;
    end
  end

  // One-cycle ready pulse per accepted request; rdata holds between.
  always_comb begin
    ready_d = accept;
    rdata_d = accept ? cur : rdata_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit_q <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
      ien_q   <= 1'b0;
      rel_q   <= 1'b0;
      event_q <= 1'b0;
      pre_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      limit_q <= limit_d;
      count_q <= count_d;
      run_q   <= run_d;
      ien_q   <= ien_d;
      rel_q   <= rel_d;
      event_q <= event_d;
      pre_q   <= pre_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.irq   = event_q & ien_q;

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: prescale-1 and prescale-4 instances driven in
// lockstep and compared each cycle against a rule-level model.
module tb_bus_timer;
  import Types_pkg::*;

  localparam int NDUT = 2;

  logic     clk = 1'b0;
  logic     reset;
  logic     valid;
  word_t    address;
  wstrobe_t wstrobe;
  word_t    wdata;

  Bus b0 ();
  Bus b1 ();

  assign b0.valid   = valid;
  assign b0.address = address;
  assign b0.wstrobe = wstrobe;
  assign b0.wdata   = wdata;
  assign b1.valid   = valid;
  assign b1.address = address;
  assign b1.wstrobe = wstrobe;
  assign b1.wdata   = wdata;

  bus_timer #(.PRESCALE(1)) u_p1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  bus_timer #(.PRESCALE(4)) u_p4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  always #5 clk = ~clk;

  logic  o_ready [NDUT];
  word_t o_rdata [NDUT];
  logic  o_irq   [NDUT];

  assign o_ready[0] = b0.ready;
  assign o_rdata[0] = b0.rdata;
  assign o_irq[0]   = b0.irq;
  assign o_ready[1] = b1.ready;
  assign o_rdata[1] = b1.rdata;
  assign o_irq[1]   = b1.irq;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference state, one slot per instance.
  word_t m_limit [NDUT];
  word_t m_count [NDUT];
  bit    m_run   [NDUT];
  bit    m_ien   [NDUT];
  bit    m_rel   [NDUT];
  bit    m_evt   [NDUT];
  int    m_phase [NDUT];
  bit    m_ready [NDUT];
  word_t m_rdata [NDUT];

  function automatic int ps_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic word_t lane_merge(
    input word_t old, input word_t nw, input wstrobe_t st);
    word_t mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (st[i]) mask = mask | (32'hFF << (8 * i));
    end
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic word_t m_reg(input int k, input logic [1:0] off);
    case (off)
      2'd0:    return m_limit[k];
      2'd1:    return m_count[k];
      2'd2:    return {29'd0, m_rel[k], m_ien[k], m_run[k]};
      default: return {31'd0, m_evt[k]};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_limit[k] = '0;
      m_count[k] = '0;
      m_run[k]   = 1'b0;
      m_ien[k]   = 1'b0;
      m_rel[k]   = 1'b0;
      m_evt[k]   = 1'b0;
      m_phase[k] = 0;
      m_ready[k] = 1'b0;
      m_rdata[k] = '0;
    end
  endtask

  // Apply the timer rules for one rising edge with current bus inputs.
  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      bit         acc;
      bit         wrq;
      bit         tk;
      bit         hit;
      bit         nrun;
      logic [1:0] off;
      word_t      cur;
      word_t      nw;
      word_t      ncount;
      acc    = valid && !m_ready[k];
      wrq    = acc && (wstrobe != 4'h0);
      off    = address[3:2];
      cur    = m_reg(k, off);
      nw     = lane_merge(cur, wdata, wstrobe);
      tk     = m_run[k] && (m_phase[k] == ps_of(k) - 1);
      hit    = tk && (m_count[k] == m_limit[k]);
      ncount = m_count[k];
      nrun   = m_run[k];
      if (hit) begin
        if (m_rel[k]) ncount = '0;
        else nrun = 1'b0;
      end else if (tk) begin
        ncount = m_count[k] + 32'd1;
      end
      m_phase[k] = (m_run[k] && !tk) ? m_phase[k] + 1 : 0;
      if (wrq && off == 2'd0) m_limit[k] = nw;
      if (wrq && off == 2'd1) begin
        ncount = nw;
        nrun   = m_run[k];
      end
      if (wrq && off == 2'd2) begin
        ncount   = m_count[k];
        nrun     = nw[0];
        m_ien[k] = nw[1];
        m_rel[k] = nw[2];
      end
      if (wrq && off == 2'd3 && wstrobe[0] && wdata[0]) m_evt[k] = 1'b0;
      if (hit) m_evt[k] = 1'b1;
      m_count[k] = ncount;
      m_run[k]   = nrun;
      if (acc) m_rdata[k] = cur;
      m_ready[k] = acc;
    end
  endtask

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    cyc++;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("ready[%0d]", k), word_t'(o_ready[k]),
          word_t'(m_ready[k]));
      chk($sformatf("rdata[%0d]", k), o_rdata[k], m_rdata[k]);
      chk($sformatf("irq[%0d]", k), word_t'(o_irq[k]),
          word_t'(m_evt[k] & m_ien[k]));
    end
  endtask

  task automatic xfer(input logic [1:0] off, input wstrobe_t st,
                      input word_t d, output word_t rd0,
                      output word_t rd1);
    valid   = 1'b1;
    address = {28'h0, off, 2'b00};
    wstrobe = st;
    wdata   = d;
    step();
    chk("ready_after_valid0", word_t'(o_ready[0]), 32'd1);
    chk("ready_after_valid1", word_t'(o_ready[1]), 32'd1);
    rd0     = o_rdata[0];
    rd1     = o_rdata[1];
    valid   = 1'b0;
    wstrobe = 4'h0;
    step();
    chk("ready_drop0", word_t'(o_ready[0]), 32'd0);
  endtask

  task automatic wait_irq(input int k, input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound && t < 0; i++) begin
      step();
      if (o_irq[k] === 1'b1) t = cyc;
    end
  endtask

  initial begin
    word_t      rd0;
    word_t      rd1;
    int         t0;
    int         t1;
    int         tw;
    logic [1:0] roff;
    wstrobe_t   rst;
    word_t      rdat;

    reset   = 1'b1;
    valid   = 1'b0;
    address = '0;
    wstrobe = 4'h0;
    wdata   = '0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    chk("rst_ready", word_t'(o_ready[0]), 32'd0);
    chk("rst_irq", word_t'(o_irq[0]), 32'd0);
    chk("rst_rdata", o_rdata[0], 32'd0);

    for (int i = 0; i < 4; i++) begin
      xfer(2'(i), 4'h0, '0, rd0, rd1);
      chk($sformatf("rst_reg%0d_p1", i), rd0, 32'd0);
      chk($sformatf("rst_reg%0d_p4", i), rd1, 32'd0);
    end

    xfer(2'd0, 4'hF, 32'hAABBCCDD, rd0, rd1);
    xfer(2'd0, 4'h5, 32'h11223344, rd0, rd1);
    xfer(2'd0, 4'h0, '0, rd0, rd1);
    chk("lane_merge_p1", rd0, 32'hAA22CC44);
    chk("lane_merge_p4", rd1, 32'hAA22CC44);

    xfer(2'd1, 4'hF, 32'd0, rd0, rd1);
    xfer(2'd0, 4'hF, 32'd5, rd0, rd1);
    xfer(2'd2, 4'hF, 32'd3, rd0, rd1);
    repeat (10) step();
    xfer(2'd1, 4'h0, '0, rd0, rd1);
    chk("oneshot_count", rd0, 32'd5);
    xfer(2'd3, 4'h0, '0, rd0, rd1);
    chk("oneshot_event", rd0, 32'd1);
    chk("oneshot_irq", word_t'(o_irq[0]), 32'd1);
    xfer(2'd2, 4'h0, '0, rd0, rd1);
    chk("oneshot_run_off", rd0, 32'd2);
    repeat (10) step();
    xfer(2'd1, 4'h0, '0, rd0, rd1);
    chk("oneshot_hold", rd0, 32'd5);

    xfer(2'd2, 4'hF, 32'd0, rd0, rd1);
    xfer(2'd3, 4'h1, 32'd1, rd0, rd1);
    xfer(2'd1, 4'hF, 32'd0, rd0, rd1);
    xfer(2'd0, 4'hF, 32'd3, rd0, rd1);
    xfer(2'd2, 4'hF, 32'd7, rd0, rd1);
    wait_irq(0, 20, t0);
    xfer(2'd3, 4'h1, 32'd1, rd0, rd1);
    chk("clear_irq", word_t'(o_irq[0]), 32'd0);
    wait_irq(0, 20, t1);
    chk("period", word_t'(t1 - t0), 32'd4);
    xfer(2'd3, 4'h1, 32'd1, rd0, rd1);
    step();
    xfer(2'd3, 4'h1, 32'd1, rd0, rd1);
    chk("set_beats_clear", word_t'(o_irq[0]), 32'd1);

    xfer(2'd1, 4'hF, 32'h100, rd0, rd1);
    xfer(2'd1, 4'h0, '0, rd0, rd1);
    chk("count_write_wins", rd0, 32'h101);
    xfer(2'd2, 4'hF, 32'd0, rd0, rd1);

    xfer(2'd3, 4'h1, 32'd1, rd0, rd1);
    xfer(2'd0, 4'hF, 32'hFFFFFFFF, rd0, rd1);
    xfer(2'd1, 4'hF, 32'hFFFFFFFE, rd0, rd1);
    xfer(2'd2, 4'hF, 32'd3, rd0, rd1);
    tw = cyc - 1;
    wait_irq(0, 20, t0);
    chk("p1_match_time", word_t'(t0 - tw), 32'd2);
    wait_irq(1, 20, t1);
    chk("p4_match_time", word_t'(t1 - tw), 32'd8);
    xfer(2'd1, 4'h0, '0, rd0, rd1);
    chk("p1_final_count", rd0, 32'hFFFFFFFF);
    chk("p4_final_count", rd1, 32'hFFFFFFFF);

    valid   = 1'b1;
    address = {28'h0, 2'd3, 2'b00};
    wstrobe = 4'h0;
    step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_ready0", word_t'(o_ready[0]), 32'd0);
    chk("async_rst_irq0", word_t'(o_irq[0]), 32'd0);
    chk("async_rst_ready1", word_t'(o_ready[1]), 32'd0);
    chk("async_rst_irq1", word_t'(o_irq[1]), 32'd0);
    valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(2'(i), 4'h0, '0, rd0, rd1);
      chk($sformatf("post_rst_reg%0d", i), rd0, 32'd0);
    end

    for (int n = 0; n < 400; n++) begin
      roff = 2'($urandom_range(0, 3));
      rst  = ($urandom_range(0, 1) == 0) ? 4'h0
           : 4'($urandom_range(1, 15));
      rdat = $urandom;
      if (roff != 2'd2 && $urandom_range(0, 1) == 1) begin
        rdat = $urandom_range(0, 9);
      end
      xfer(roff, rst, rdat, rd0, rd1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
